pla_sweep_controller: RTL and testbench

//  Exhaustive-sweep sequencer for one single-output combinational PLA benchmark (inputs x0..x6, output y0).

---
 rtl/pla_sweep_pkg.sv | 27 ++
 rtl/pla_sweep_misr.sv | 39 +++
 rtl/pla_sweep_controller.sv | 148 ++++++++++++++
 tb/tb_pla_sweep_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA exhaustive-sweep controller.
// Holds the FSM state encoding, the default MISR polynomial and width helpers.
package pla_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    // CCITT polynomial for the default 16-bit signature.
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Number of distinct input vectors for an n-input DUT.
    function automatic int unsigned vec_space(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pla_sweep_misr.sv
// Single-input MISR: shifts left, folds the MSB back through POLY and XORs din
// into bit 0 on each enabled cycle.
module pla_sweep_misr #(
    parameter int unsigned          SIG_W = 16,
    parameter logic [SIG_W-1:0]     POLY  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] feedback;

    always_comb begin
        feedback = sig_q[SIG_W-1] ? POLY : '0;
        sig_d    = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (shift_en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ feedback ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/pla_sweep_controller.sv
// Exhaustive-sweep sequencer: walks every input vector of a combinational PLA,
// samples y0 after a settle delay and scores it against a host-loaded golden table.
module pla_sweep_controller
    import pla_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 7,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned SIG_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              gold_we,
    input  logic [N_IN-1:0]   gold_addr,
    input  logic              gold_bit,
    output logic [N_IN-1:0]   vec_out,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     onset_count,
    output logic [N_IN:0]     mismatch_count,
    output logic              first_mm_valid,
    output logic [N_IN-1:0]   first_mm_vec,
    output logic [SIG_W-1:0]  signature
);

    localparam int unsigned DEPTH = vec_space(N_IN);
    localparam int unsigned SET_W = cnt_width(SETTLE);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE);
    localparam logic [N_IN-1:0]  IDX_LAST    = '1;

    sweep_state_e      state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [N_IN:0]     onset_q, onset_d;
    logic [N_IN:0]     mm_q, mm_d;
    logic              fmv_q, fmv_d;
    logic [N_IN-1:0]   fmvec_q, fmvec_d;
    logic [DEPTH-1:0]  gold_q, gold_d;

    logic              misr_clear;
    logic              misr_shift;
    logic              sample;
    logic              mismatch;

    assign sample   = (state_q == RUN) && (settle_q == SETTLE_LAST);
    assign mismatch = dut_y ^ gold_q[idx_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        onset_d    = onset_q;
        mm_d       = mm_q;
        fmv_d      = fmv_q;
        fmvec_d    = fmvec_q;
        gold_d     = gold_q;
        misr_clear = 1'b0;
        misr_shift = 1'b0;

        // Table is frozen while a sweep is running so results stay self-consistent.
        if (gold_we && (state_q != RUN)) begin
            gold_d[gold_addr] = gold_bit;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    settle_d   = '0;
                    onset_d    = '0;
                    mm_d       = '0;
                    fmv_d      = 1'b0;
                    fmvec_d    = '0;
                    misr_clear = 1'b1;
                end
            end
            RUN: begin
                if (sample) begin
                    misr_shift = 1'b1;
                    onset_d    = onset_q + {{N_IN{1'b0}}, dut_y};
                    mm_d       = mm_q + {{N_IN{1'b0}}, mismatch};
                    if (mismatch && !fmv_q) begin
                        fmv_d   = 1'b1;
                        fmvec_d = idx_q;
                    end
                    settle_d = '0;
                    // Last vector stays on vec_out after the sweep ends.
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            onset_q  <= '0;
            mm_q     <= '0;
            fmv_q    <= 1'b0;
            fmvec_q  <= '0;
            gold_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            onset_q  <= onset_d;
            mm_q     <= mm_d;
            fmv_q    <= fmv_d;
            fmvec_q  <= fmvec_d;
            gold_q   <= gold_d;
        end
    end

    pla_sweep_misr #(
        .SIG_W (SIG_W),
        .POLY  (SIG_W'(MISR_POLY))
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (misr_clear),
        .shift_en (misr_shift),
        .din      (dut_y),
        .sig      (signature)
    );

    assign vec_out        = idx_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign onset_count    = onset_q;
    assign mismatch_count = mm_q;
    assign first_mm_valid = fmv_q;
    assign first_mm_vec   = fmvec_q;

endmodule

// File: tb/tb_pla_sweep_controller.sv
// Directed bench for pla_sweep_controller at default parameters (N_IN=7, SETTLE=1,
// SIG_W=16) with a behavioural stub standing in for the PLA under test.
module tb_pla_sweep_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        gold_we;
    logic [6:0]  gold_addr;
    logic        gold_bit;
    logic [6:0]  vec_out;
    logic        dut_y;
    logic        busy;
    logic        done;
    logic [7:0]  onset_count;
    logic [7:0]  mismatch_count;
    logic        first_mm_valid;
    logic [6:0]  first_mm_vec;
    logic [15:0] signature;

    // 0: y0 = x0, 1: y0 = 0, 2: y0 = 1
    logic [1:0]  stub_mode;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    always_comb begin
        dut_y = 1'b0;
        case (stub_mode)
            2'd0:    dut_y = vec_out[0];
            2'd2:    dut_y = 1'b1;
            default: dut_y = 1'b0;
        endcase
    end

    pla_sweep_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .gold_we        (gold_we),
        .gold_addr      (gold_addr),
        .gold_bit       (gold_bit),
        .vec_out        (vec_out),
        .dut_y          (dut_y),
        .busy           (busy),
        .done           (done),
        .onset_count    (onset_count),
        .mismatch_count (mismatch_count),
        .first_mm_valid (first_mm_valid),
        .first_mm_vec   (first_mm_vec),
        .signature      (signature)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference MISR over the 128-vector y0 stream for a given stub mode.
    function automatic logic [15:0] misr_model(input int mode);
        logic [15:0] s;
        logic        y;
        s = '0;
        for (int v = 0; v < 128; v++) begin
            y = (mode == 0) ? v[0] : (mode == 2);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, y};
        end
        return s;
    endfunction

    // mode 0: all zero, 1: gold[v] = v[0], 2: all one
    task automatic load_gold(input int mode);
        for (int v = 0; v < 128; v++) begin
            gold_we   = 1'b1;
            gold_addr = 7'(v);
            gold_bit  = (mode == 1) ? v[0] : (mode == 2);
            step();
        end
        gold_we = 1'b0;
    endtask

    // Starts a sweep and counts busy cycles. Optional disturbances (vector index,
    // -1 = none): extra start pulse, dropped gold write, mid-sweep reset.
    task automatic run_sweep(input int start_at, input int we_at, input int rst_at,
                             input bit check_step, input bit we_with_start,
                             output int cycles);
        bit s_done = 0;
        bit w_done = 0;
        start = 1'b1;
        if (we_with_start) begin
            gold_we   = 1'b1;
            gold_addr = 7'd0;
            gold_bit  = 1'b1;
        end
        step();
        start   = 1'b0;
        gold_we = 1'b0;
        cycles  = busy ? 1 : 0;
        while (busy && cycles < 1000) begin
            if (int'(vec_out) == start_at && !s_done) begin
                start  = 1'b1;
                s_done = 1;
            end
            if (int'(vec_out) == we_at && !w_done) begin
                gold_we   = 1'b1;
                gold_addr = 7'd3;
                gold_bit  = 1'b0;
                w_done    = 1;
            end
            if (int'(vec_out) == rst_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                return;
            end
            step();
            start   = 1'b0;
            gold_we = 1'b0;
            if (busy) cycles++;
            if (check_step && cycles == 101) chk("vec_out_step", 32'(vec_out), 32'd50);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        gold_we   = 1'b0;
        gold_addr = '0;
        gold_bit  = 1'b0;
        stub_mode = 2'd0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vec", 32'(vec_out), 32'd0);
        chk("rst_onset", 32'(onset_count), 32'd0);
        chk("rst_mm", 32'(mismatch_count), 32'd0);
        chk("rst_fmv", 32'(first_mm_valid), 32'd0);
        chk("rst_sig", 32'(signature), 32'd0);

        // y0 = x0 against an all-zero table
        run_sweep(-1, -1, -1, 1'b1, 1'b0, cyc);
        chk("s1_cycles", 32'(cyc), 32'd256);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_busy", 32'(busy), 32'd0);
        chk("s1_vec_hold", 32'(vec_out), 32'd127);
        chk("s1_onset", 32'(onset_count), 32'd64);
        chk("s1_mm", 32'(mismatch_count), 32'd64);
        chk("s1_fmv", 32'(first_mm_valid), 32'd1);
        chk("s1_fmvec", 32'(first_mm_vec), 32'd1);
        chk("s1_sig", 32'(signature), 32'(misr_model(0)));

        // Matching golden table
        load_gold(1);
        run_sweep(-1, -1, -1, 1'b0, 1'b0, cyc);
        chk("s2_cycles", 32'(cyc), 32'd256);
        chk("s2_mm", 32'(mismatch_count), 32'd0);
        chk("s2_fmv", 32'(first_mm_valid), 32'd0);
        chk("s2_onset", 32'(onset_count), 32'd64);

        // Constant-zero output
        stub_mode = 2'd1;
        run_sweep(-1, -1, -1, 1'b0, 1'b0, cyc);
        chk("s3_onset", 32'(onset_count), 32'd0);
        chk("s3_sig", 32'(signature), 32'd0);
        chk("s3_mm", 32'(mismatch_count), 32'd64);
        chk("s3_fmvec", 32'(first_mm_vec), 32'd1);

        // Constant-one output against an all-one table
        stub_mode = 2'd2;
        load_gold(2);
        run_sweep(-1, -1, -1, 1'b0, 1'b0, cyc);
        chk("s4_onset", 32'(onset_count), 32'd128);
        chk("s4_mm", 32'(mismatch_count), 32'd0);
        chk("s4_sig", 32'(signature), 32'(misr_model(2)));

        // Start and gold write during a sweep are both ignored
        stub_mode = 2'd0;
        run_sweep(40, 50, -1, 1'b0, 1'b0, cyc);
        chk("s5_cycles", 32'(cyc), 32'd256);
        chk("s5_mm", 32'(mismatch_count), 32'd64);
        chk("s5_fmvec", 32'(first_mm_vec), 32'd0);
        stub_mode = 2'd2;
        run_sweep(-1, -1, -1, 1'b0, 1'b0, cyc);
        chk("s5_table_frozen", 32'(mismatch_count), 32'd0);

        // Reset mid-sweep clears state and the golden table
        stub_mode = 2'd0;
        run_sweep(-1, -1, 40, 1'b0, 1'b0, cyc);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_onset", 32'(onset_count), 32'd0);
        chk("rst_mid_vec", 32'(vec_out), 32'd0);
        chk("rst_mid_sig", 32'(signature), 32'd0);

        // Fresh sweep; gold[0]=1 written alongside start must be seen by vector 0
        run_sweep(-1, -1, -1, 1'b0, 1'b1, cyc);
        chk("s6_cycles", 32'(cyc), 32'd256);
        chk("s6_onset", 32'(onset_count), 32'd64);
        chk("s6_mm", 32'(mismatch_count), 32'd65);
        chk("s6_fmvec", 32'(first_mm_vec), 32'd0);
        chk("s6_sig", 32'(signature), 32'(misr_model(0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
